// File: rtl/fht_pkg.sv
// Shared definitions for the FHT unload path: default widths, point count, FSM states, bit reversal.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fht_pkg;

  localparam int A_BIT_DEF = 8;
  localparam int D_BIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fht_state_e;

  // Total number of result points spread over the four banks.
  function automatic int unsigned n_points(input int unsigned a_bit);
    return 32'd4 << a_bit;
  endfunction

  // Reverse the low w bits of v; the result is right-aligned and zero-extended.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = {<<{v}};
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/fht_unload_if.sv
// Handshake/bus bundle between fht_unload, the four result banks and the sample sink.
// Latency: n/a (wiring only).
// Backpressure: iREADY from the sink; oVALID/payload hold until accepted.
interface fht_unload_if
  import fht_pkg::*;
#(
  parameter int A_BIT = A_BIT_DEF,
  parameter int D_BIT = D_BIT_DEF
) ();

  logic               iSTART;
  logic [A_BIT-1:0]   oADDR_RD_0;
  logic [A_BIT-1:0]   oADDR_RD_1;
  logic [A_BIT-1:0]   oADDR_RD_2;
  logic [A_BIT-1:0]   oADDR_RD_3;
  logic [D_BIT-1:0]   iDATA_0;
  logic [D_BIT-1:0]   iDATA_1;
  logic [D_BIT-1:0]   iDATA_2;
  logic [D_BIT-1:0]   iDATA_3;
  logic [D_BIT-1:0]   oDATA;
  logic [A_BIT+1:0]   oIDX;
  logic               oVALID;
  logic               iREADY;
  logic               oLAST;
  logic               oBUSY;
  logic               oDONE;

  // Unload sequencer side.
  modport master (
    input  iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    output oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
  );

  // Controller / banks / sink side.
  modport slave (
    output iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    input  oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
  );

endinterface

// File: rtl/fht_unload_fifo.sv
// Two-entry output FIFO with occupancy count; head is always presented on dout.
// Latency: a push is visible at dout the cycle after it is written into an empty FIFO.
// Backpressure: none internally; the writer guarantees it never pushes into a full FIFO without a pop.
module fht_unload_fifo #(
  parameter int W = 27
) (
  input  logic         iCLK,
  input  logic         iRESET,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Pointer, storage and occupancy update; simultaneous push and pop keep the count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  // State registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fht_unload.sv
// Walks all 4*2^A_BIT FHT result points, reads the four banks and streams samples out (optional macro FHT_UNLOAD_BITREV_EN: bit-reversed order).
// Latency: start sampled at E0, first oVALID after E2; sustains one sample per clock with iREADY held high.
// Backpressure: reads are only issued while FIFO + in-flight - pop < 2, so the 2-entry FIFO never overflows and oVALID/payload hold while stalled.
module fht_unload
  import fht_pkg::*;
#(
  parameter int A_BIT = A_BIT_DEF,
  parameter int D_BIT = D_BIT_DEF
) (
  input  logic iCLK,
  input  logic iRESET,
  fht_unload_if.master bus
);

  localparam int KW = A_BIT + 2;
  localparam int FW = D_BIT + A_BIT + 3;
  localparam logic [KW-1:0] K_LAST = KW'(n_points(A_BIT) - 1);

  // Read counter k to point index p.
  function automatic logic [KW-1:0] map_pt(input logic [KW-1:0] k);
`ifdef FHT_UNLOAD_BITREV_EN
    return KW'(bitrev(32'(k), KW));
`else
    return k;
`endif
  endfunction

  fht_state_e       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic             done_q, done_d;
  logic             s1_vld_q, s1_vld_d;
  logic [KW-1:0]    s1_p_q, s1_p_d;
  logic             s1_last_q, s1_last_d;

  logic [KW-1:0]    k_inc;
  logic [KW-1:0]    p_cur;
  logic [2:0]       occ;
  logic             issue;
  logic [D_BIT-1:0] sel_data;
  logic [FW-1:0]    fifo_din;
  logic [FW-1:0]    fifo_dout;
  logic [1:0]       fifo_cnt;
  logic             fifo_pop;
  logic             out_vld;
  logic             head_last;
  logic [KW-1:0]    head_idx;
  logic [D_BIT-1:0] head_data;

  assign k_inc = k_q + KW'(1);
  assign p_cur = map_pt(k_q);

  // Output side of the FIFO: head unpacking and transfer detection.
  assign head_last = fifo_dout[FW-1];
  assign head_idx  = fifo_dout[FW-2 -: KW];
  assign head_data = fifo_dout[D_BIT-1:0];
  assign out_vld   = (fifo_cnt != 2'd0);
  assign fifo_pop  = out_vld & bus.iREADY;

  // Issue a read only if its sample is guaranteed a FIFO slot when it lands.
  always_comb begin
    occ   = {1'b0, fifo_cnt} + {2'b00, s1_vld_q} - {2'b00, fifo_pop};
    issue = (state_q == ST_RUN) && (occ < 3'd2);
  end

  // Pick the bank that served the read now returning, pack with its index.
  always_comb begin
    sel_data = bus.iDATA_0;
    case (s1_p_q[1:0])
      2'd0:    sel_data = bus.iDATA_0;
      2'd1:    sel_data = bus.iDATA_1;
      2'd2:    sel_data = bus.iDATA_2;
      default: sel_data = bus.iDATA_3;
    endcase
    fifo_din = {s1_last_q, s1_p_q, sel_data};
  end

  // Next-state, read counter and address generation; address holds unless a read is issued.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    s1_vld_d  = issue;
    s1_p_d    = p_cur;
    s1_last_d = (k_q == K_LAST);
    case (state_q)
      ST_IDLE: begin
        // The cycle carrying oDONE still reads as idle; a start there is dropped.
        if (bus.iSTART && !done_q) begin
          state_d = ST_RUN;
          k_d     = '0;
          addr_d  = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (k_q == K_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            k_d    = k_inc;
            addr_d = A_BIT'(map_pt(k_inc) >> 2);
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && head_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers and the bank-select/index pipe stage that tracks the RAM.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_p_q    <= '0;
      s1_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      s1_vld_q  <= s1_vld_d;
      s1_p_q    <= s1_p_d;
      s1_last_q <= s1_last_d;
    end
  end

  fht_unload_fifo #(
    .W (FW)
  ) u_fifo (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .push   (s1_vld_q),
    .din    (fifo_din),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .count  (fifo_cnt)
  );

  assign bus.oADDR_RD_0 = addr_q;
  assign bus.oADDR_RD_1 = addr_q;
  assign bus.oADDR_RD_2 = addr_q;
  assign bus.oADDR_RD_3 = addr_q;
  assign bus.oDATA      = head_data;
  assign bus.oIDX       = head_idx;
  assign bus.oVALID     = out_vld;
  assign bus.oLAST      = head_last & out_vld;
  assign bus.oBUSY      = (state_q != ST_IDLE);
  assign bus.oDONE      = done_q;

endmodule

// File: tb/tb_fht_unload.sv
// Bench for fht_unload: bank models hold p*3, a scoreboard holds the expected stream.
// Scenario table drives full streams under different sink behaviours and injections.
module tb_fht_unload;

  localparam int A_BIT = 8;
  localparam int D_BIT = 16;
  localparam int KW    = A_BIT + 2;
  localparam int N     = 4 << A_BIT;

  logic iCLK = 1'b0;
  logic iRESET;

  always #5 iCLK = ~iCLK;

  fht_unload_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

  fht_unload #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  // Synchronous-read bank models: bank b, address a holds (4a+b)*3.
  always @(posedge iCLK) begin
    bus.iDATA_0 <= 16'((int'(bus.oADDR_RD_0) * 4 + 0) * 3);
    bus.iDATA_1 <= 16'((int'(bus.oADDR_RD_1) * 4 + 1) * 3);
    bus.iDATA_2 <= 16'((int'(bus.oADDR_RD_2) * 4 + 2) * 3);
    bus.iDATA_3 <= 16'((int'(bus.oADDR_RD_3) * 4 + 3) * 3);
  end

  typedef struct {
    int idx;
    int data;
    bit last;
  } exp_t;

  typedef struct {
    int mode;       // 0: ready high, 1: random ready, 2: ready low for 20 cycles
    int start_at;   // transfer count at which a stray start is pulsed (-1: none)
    int reset_at;   // transfer count at which reset is pulsed (-1: none)
    int exp_xfers;
    bit exp_done;
    bit sod;        // pulse start in the oDONE cycle and the cycle after
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic int tb_map(input int k);
`ifdef FHT_UNLOAD_BITREV_EN
    int r;
    r = 0;
    for (int i = 0; i < KW; i++) begin
      if (k[i]) r = r | (1 << (KW - 1 - i));
    end
    return r;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr0"}, int'(bus.oADDR_RD_0), 0);
    chk({tag, "_addr1"}, int'(bus.oADDR_RD_1), 0);
    chk({tag, "_addr2"}, int'(bus.oADDR_RD_2), 0);
    chk({tag, "_addr3"}, int'(bus.oADDR_RD_3), 0);
    chk({tag, "_data"},  int'(bus.oDATA), 0);
    chk({tag, "_idx"},   int'(bus.oIDX), 0);
    chk({tag, "_valid"}, int'(bus.oVALID), 0);
    chk({tag, "_last"},  int'(bus.oLAST), 0);
    chk({tag, "_busy"},  int'(bus.oBUSY), 0);
    chk({tag, "_done"},  int'(bus.oDONE), 0);
  endtask

  task automatic run_case(input int id, input vec_t v);
    int   cyc, xfers, last_cyc, prev_idx, prev_data;
    bit   done_seen, prev_stall, injected;
    exp_t e;
    int   first_idx [4];
    first_idx[0] = 0;
    first_idx[1] = 512;
    first_idx[2] = 256;
    first_idx[3] = 768;

    sb.delete();
    for (int k = 0; k < N; k++) begin
      e.idx  = tb_map(k);
      e.data = tb_map(k) * 3;
      e.last = (k == N - 1);
      sb.push_back(e);
    end

    @(negedge iCLK);
    bus.iSTART = 1'b1;
    bus.iREADY = (v.mode != 2);
    @(negedge iCLK);
    bus.iSTART = 1'b0;
    chk($sformatf("v%0d_busy_after_start", id), int'(bus.oBUSY), 1);
    chk($sformatf("v%0d_addr_k0", id), int'(bus.oADDR_RD_0), 0);
    chk($sformatf("v%0d_addr_k0_b3", id), int'(bus.oADDR_RD_3), 0);

    cyc = 0; xfers = 0; last_cyc = -1; done_seen = 0; prev_stall = 0; injected = 0;
    prev_idx = 0; prev_data = 0;
    while (1) begin
      if (cyc == 1) chk($sformatf("v%0d_valid_e1", id), int'(bus.oVALID), 0);
      if (cyc == 2) chk($sformatf("v%0d_valid_e2", id), int'(bus.oVALID), 1);
      if (prev_stall) begin
        chk($sformatf("v%0d_stall_valid", id), int'(bus.oVALID), 1);
        chk($sformatf("v%0d_stall_idx", id), int'(bus.oIDX), prev_idx);
        chk($sformatf("v%0d_stall_data", id), int'(bus.oDATA), prev_data);
      end

      if (bus.oDONE) begin
        done_seen = 1;
        chk($sformatf("v%0d_done_after_last", id), cyc, last_cyc + 1);
        chk($sformatf("v%0d_busy_with_done", id), int'(bus.oBUSY), 0);
        chk($sformatf("v%0d_xfers_at_done", id), xfers, N);
        if (v.sod) begin
          bus.iSTART = 1'b1;
          @(negedge iCLK);
          chk($sformatf("v%0d_start_on_done_ignored", id), int'(bus.oBUSY), 0);
          @(negedge iCLK);
          bus.iSTART = 1'b0;
          chk($sformatf("v%0d_start_after_done", id), int'(bus.oBUSY), 1);
          iRESET = 1'b1;
          @(negedge iCLK);
          iRESET = 1'b0;
        end
        break;
      end

      if (v.reset_at >= 0 && xfers == v.reset_at) begin
        iRESET = 1'b1;
        #1;
        chk_zero_outputs($sformatf("v%0d_midreset", id));
        @(negedge iCLK);
        iRESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge iCLK);
          chk($sformatf("v%0d_no_done_after_reset", id), int'(bus.oDONE), 0);
          chk($sformatf("v%0d_idle_after_reset", id), int'(bus.oBUSY), 0);
        end
        break;
      end

      bus.iSTART = 1'b0;
      if (v.start_at >= 0 && xfers == v.start_at && !injected) begin
        bus.iSTART = 1'b1;
        injected   = 1;
      end

      case (v.mode)
        0:       bus.iREADY = 1'b1;
        1:       bus.iREADY = 1'($urandom_range(0, 1));
        default: bus.iREADY = (cyc >= 20);
      endcase

      if (v.mode == 2 && cyc >= 3 && cyc < 20) begin
        chk($sformatf("v%0d_hold_addr", id), int'(bus.oADDR_RD_0), tb_map(2) >> 2);
        chk($sformatf("v%0d_hold_idx", id), int'(bus.oIDX), tb_map(0));
      end

      if (bus.oVALID && bus.iREADY) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_extra_xfer", id), xfers, N);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_idx", id), int'(bus.oIDX), e.idx);
          chk($sformatf("v%0d_data", id), int'(bus.oDATA), e.data);
          chk($sformatf("v%0d_last", id), int'(bus.oLAST), int'(e.last));
`ifdef FHT_UNLOAD_BITREV_EN
          if (xfers < 4) chk($sformatf("v%0d_bitrev_first", id), int'(bus.oIDX), first_idx[xfers]);
`endif
          if (e.last) last_cyc = cyc;
        end
        xfers++;
      end

      prev_stall = bus.oVALID && !bus.iREADY;
      prev_idx   = int'(bus.oIDX);
      prev_data  = int'(bus.oDATA);

      if (cyc > 4 * N) begin
        chk($sformatf("v%0d_timeout_cycles", id), cyc, 4 * N);
        break;
      end
      @(negedge iCLK);
      cyc++;
    end

    bus.iSTART = 1'b0;
    chk($sformatf("v%0d_xfers", id), xfers, v.exp_xfers);
    chk($sformatf("v%0d_done_seen", id), int'(done_seen), int'(v.exp_done));
    if (v.exp_done) chk($sformatf("v%0d_sb_empty", id), sb.size(), 0);
    if (v.mode == 0 && v.exp_done) chk($sformatf("v%0d_last_xfer_cycle", id), last_cyc, N + 1);
  endtask

  initial begin
    vecs[0] = '{mode: 0, start_at: -1,  reset_at: -1,  exp_xfers: N,   exp_done: 1, sod: 0};
    vecs[1] = '{mode: 1, start_at: -1,  reset_at: -1,  exp_xfers: N,   exp_done: 1, sod: 0};
    vecs[2] = '{mode: 2, start_at: -1,  reset_at: -1,  exp_xfers: N,   exp_done: 1, sod: 0};
    vecs[3] = '{mode: 0, start_at: 500, reset_at: -1,  exp_xfers: N,   exp_done: 1, sod: 0};
    vecs[4] = '{mode: 1, start_at: -1,  reset_at: 300, exp_xfers: 300, exp_done: 0, sod: 0};
    vecs[5] = '{mode: 0, start_at: -1,  reset_at: -1,  exp_xfers: N,   exp_done: 1, sod: 1};

    iRESET     = 1'b1;
    bus.iSTART = 1'b0;
    bus.iREADY = 1'b0;
    repeat (2) @(negedge iCLK);
    chk_zero_outputs("por");
    iRESET = 1'b0;
    @(negedge iCLK);
    chk("idle_busy", int'(bus.oBUSY), 0);

    for (int i = 0; i < 6; i++) begin
      run_case(i, vecs[i]);
      repeat (3) @(negedge iCLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
